// File: rtl/bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
// State encoding, default sizes and the counter-width helper.
package bcd_pkg;

    localparam logic IDLE  = 1'b0;
    localparam logic SHIFT = 1'b1;

    localparam int WIDTH_DEF  = 8;
    localparam int DIGITS_DEF = 3;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd_8_bit.sv
// Bit-serial shift-and-add-3 binary to packed BCD converter.
// One input bit per clock; done strobes with bcd valid.
import bcd_pkg::*;

module bin_to_bcd_8_bit #(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic          state;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] shreg;
    logic [SW-1:0] scratch;
    logic [SW-1:0] adj;
    logic [SW-1:0] scratch_nxt;
    logic          unused_adj_msb;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (scratch[4*i +: 4]),
            .adjusted (adj[4*i +: 4])
        );
    end

    // The top digit's MSB is shifted out; it is always 0 when sized correctly.
    assign scratch_nxt    = {adj[SW-2:0], shreg[WIDTH-1]};
    assign unused_adj_msb = adj[SW-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            scratch <= '0;
            bcd     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    shreg   <= bin;
                    scratch <= '0;
                    cnt     <= '0;
                    busy    <= 1'b1;
                    state   <= SHIFT;
                end
            end else begin
                scratch <= scratch_nxt;
                shreg   <= {shreg[WIDTH-2:0], 1'b0};
                cnt     <= cnt + 1'b1;
                if (cnt == LAST) begin
                    bcd   <= scratch_nxt;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: doc/bin_to_bcd_8_bit.md
# bin_to_bcd_8_bit

Sequential binary-to-BCD converter that sits directly downstream of the 4-bit shift-add multiplier. It captures the 8-bit product `P` on a `start` pulse and converts it to three packed BCD digits using shift-and-add-3 (double-dabble), one bit per clock. It then presents the digits with a one-cycle `done` strobe for the display-driver stage.

## Interface
- `WIDTH`, 8, binary input width; only 8 is verified.
- `DIGITS`, 3, BCD digit count; must satisfy 10^DIGITS > 2^WIDTH − 1.
- `clk`  in  1  single system clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  conversion request, sampled on the rising `clk` edge, honoured only in IDLE.
- `bin`  in  WIDTH  binary value (multiplier product `P`), captured on the accepted `start` edge.
- `bcd`  out  4*DIGITS  packed result: [11:8] hundreds, [7:4] tens, [3:0] units; held until the next completion.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle completion strobe; `bcd` is valid in the same cycle.

## Operation
- State machine has two states: IDLE and SHIFT.
- IDLE with `start`=1 at edge k:
  - shift register ← `bin`;
  - scratch digits ← 0;
  - bit counter ← 0;
  - `busy` ← 1;
  - state ← SHIFT.
- SHIFT, every edge:
  - each scratch digit ≥ 5 gets +3 (4-bit, no overflow possible);
  - then {scratch, shift register} shifts left by 1; the MSB of `bin` enters the units LSB;
  - counter increments.
- On the WIDTH-th SHIFT edge (counter = WIDTH−1):
  - `bcd` ← post-shift scratch value;
  - `done` ← 1, `busy` ← 0;
  - state ← IDLE.
- `done` is registered, high for exactly one cycle, cleared on the next edge.
- `start` while `busy` is ignored: no queueing, `bin` is not resampled.
- `start` in the `done` cycle is accepted (state is already IDLE).
- `bin` may change freely after the capturing edge.
- Arithmetic: unsigned. The hundreds digit never exceeds 2 for WIDTH=8; its upper bits are 0.

## Timing
- Reset values: `bcd`=0, `busy`=0, `done`=0, state IDLE, counter 0, scratch 0.
- Reset asserted mid-conversion: abort immediately, all outputs to reset values, no `done`.
- After reset deassertion, a `start` is accepted at the first rising edge.
- Latency: `start` accepted at edge k → `done` and valid `bcd` between edges k+8 and k+9 (WIDTH edges).
- `busy` is high between edges k and k+8.
- Throughput: one conversion every 9 cycles with `start` held or re-pulsed in the `done` cycle.
- No combinational path from inputs to outputs.

## Structure
- Shared package `bcd_pkg`:
  - state encoding constants IDLE=1'b0, SHIFT=1'b1;
  - default `WIDTH`/`DIGITS`;
  - counter width = $clog2(WIDTH).
- One sub-module, `bcd_digit_adj`: 4-bit combinational correction (out = in ≥ 5 ? in+3 : in). Instantiated DIGITS times in the top.
- Top contains the FSM, counter, shift/scratch registers and output registers.

## Test plan
- Reset, then `bin`=225 (15×15) with one-cycle `start` → `busy` for 8 cycles, `done` at edge 8, `bcd`=0x225, `done` low next cycle.
- `bin`=0 → `bcd`=0x000; `bin`=255 → `bcd`=0x255; exhaustive 0..255 against a reference model, all matching.
- Back-to-back: `bin`=99 then `start` re-pulsed with `bin`=100 in the `done` cycle → 0x099, then 0x100 exactly 9 cycles later.
- `start` pulsed at cycles k+3 and k+5 with `bin`=7 during a conversion of 42 → single `done`, `bcd`=0x042, no second conversion.
- `rst` asserted at cycle k+4 of a conversion of 200 → outputs 0 asynchronously, no `done`. A new `start` with 200 after release → 0x200.
- Chained with the multiplier: X=12, Y=13, product `P`=156 fed via `stop`→`start` → `bcd`=0x156.
